// File: rtl/rob_fill_arbiter.sv
// rob_fill_arbiter: round-robin arbiter sharing the single ROB fill port among NUM_REQ result producers.
// Define ROB_FILL_ARB_PIPE_EN to register the fill outputs (1-cycle latency) instead of the combinational ARB/HOLD path.
module rob_fill_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32,
  parameter int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_exc,
  output logic                         fill_valid,
  input  logic                         fill_ready,
  output logic [ROB_IDX_W-1:0]         fill_rob_idx,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         fill_exc,
  output logic [SRC_W-1:0]             fill_src
);

  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     winner;
  logic                 any_valid;
  logic [SRC_W-1:0]     sel;
  logic [ROB_IDX_W-1:0] sel_idx;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_exc;

  // Explicit compare keeps the wrap correct when NUM_REQ is not a power of two.
  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
    return (s == SRC_W'(NUM_REQ - 1)) ? '0 : s + 1'b1;
  endfunction

  always_comb begin
    logic [SRC_W:0] cand;
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NUM_REQ))
        cand = cand - (SRC_W+1)'(NUM_REQ);
      if (!any_valid && req_valid[cand[SRC_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    sel_exc  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == SRC_W'(i)) begin
        sel_idx  = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_exc  = req_exc[i];
      end
    end
  end

`ifndef ROB_FILL_ARB_PIPE_EN
  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state;
  logic [SRC_W-1:0] lock_id;
  logic             grant_valid;

  // HOLD pins the grant to the locked requester until the ROB takes it.
  assign sel         = (state == ST_HOLD) ? lock_id : winner;
  assign grant_valid = (state == ST_HOLD) ? req_valid[lock_id] : any_valid;

  always_comb begin
    fill_valid   = grant_valid && !flush;
    req_ready    = '0;
    fill_rob_idx = '0;
    fill_data    = '0;
    fill_exc     = 1'b0;
    fill_src     = '0;
    if (fill_valid) begin
      req_ready[sel] = fill_ready;
      fill_rob_idx   = sel_idx;
      fill_data      = sel_data;
      fill_exc       = sel_exc;
      fill_src       = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ARB;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else if (flush) begin
      state   <= ST_ARB;
      lock_id <= '0;
    end else if (state == ST_ARB) begin
      if (any_valid) begin
        if (fill_ready) begin
          rr_ptr <= next_src(winner);
        end else begin
          lock_id <= winner;
          state   <= ST_HOLD;
        end
      end
    end else if (fill_ready) begin
      rr_ptr <= next_src(lock_id);
      state  <= ST_ARB;
    end
  end
`else
  logic out_valid;
  logic accept;

  // The register takes a new winner whenever it is empty or being drained this cycle.
  assign sel        = winner;
  assign accept     = any_valid && (!out_valid || fill_ready) && !flush;
  assign fill_valid = out_valid;

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      fill_rob_idx <= '0;
      fill_data    <= '0;
      fill_exc     <= 1'b0;
      fill_src     <= '0;
      rr_ptr       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      fill_rob_idx <= sel_idx;
      fill_data    <= sel_data;
      fill_exc     <= sel_exc;
      fill_src     <= winner;
      rr_ptr       <= next_src(winner);
    end else if (fill_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rob_fill_arbiter.sv
// tb_rob_fill_arbiter: directed vectors for rob_fill_arbiter; expected fills queue up and a monitor checks each transfer.
// Directed HOLD/flush checks run in the default build; ROB_FILL_ARB_PIPE_EN selects the registered-output checks.
module tb_rob_fill_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int ROB_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int SRC_W     = 2;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         flush;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*DATA_W-1:0]    req_data;
  logic [NUM_REQ-1:0]           req_exc;
  logic                         fill_valid;
  logic                         fill_ready;
  logic [ROB_IDX_W-1:0]         fill_rob_idx;
  logic [DATA_W-1:0]            fill_data;
  logic                         fill_exc;
  logic [SRC_W-1:0]             fill_src;

  typedef struct {
    logic [SRC_W-1:0]     src;
    logic [ROB_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
    logic                 exc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total;
  int   bad;

  logic                 s_valid[NUM_REQ];
  logic [ROB_IDX_W-1:0] s_idx[NUM_REQ];
  logic [DATA_W-1:0]    s_data[NUM_REQ];
  logic                 s_exc[NUM_REQ];
  int                   s_left[NUM_REQ];
  int                   s_gen[NUM_REQ];
  logic [NUM_REQ-1:0]   fire;
  logic                 flush_seen;

  rob_fill_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ROB_IDX_W(ROB_IDX_W),
    .DATA_W   (DATA_W),
    .SRC_W    (SRC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rob_idx (req_rob_idx),
    .req_data    (req_data),
    .req_exc     (req_exc),
    .fill_valid  (fill_valid),
    .fill_ready  (fill_ready),
    .fill_rob_idx(fill_rob_idx),
    .fill_data   (fill_data),
    .fill_exc    (fill_exc),
    .fill_src    (fill_src)
  );

  always #5 clk = ~clk;

  function automatic logic [ROB_IDX_W-1:0] genIdx(int i, int n);
    return ROB_IDX_W'(16 + i * 2 + n);
  endfunction

  function automatic logic [DATA_W-1:0] genData(int i, int n);
    return 32'hC0DE_0000 + 32'(i * 256 + n);
  endfunction

  function automatic logic genExc(int i, int n);
    return 1'((i + n) % 2);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadReq(input int i, input logic [ROB_IDX_W-1:0] idx, input logic [DATA_W-1:0] data,
                         input logic exc, input int left);
    s_valid[i] = 1'b1;
    s_idx[i]   = idx;
    s_data[i]  = data;
    s_exc[i]   = exc;
    s_left[i]  = left;
    s_gen[i]   = 0;
  endtask

  task automatic pushExp(input logic [SRC_W-1:0] src, input logic [ROB_IDX_W-1:0] idx,
                         input logic [DATA_W-1:0] data, input logic exc);
    exp_t e;
    e.src  = src;
    e.idx  = idx;
    e.data = data;
    e.exc  = exc;
    sb.push_back(e);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                              = s_valid[i];
      req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]     = s_idx[i];
      req_data[i*DATA_W +: DATA_W]              = s_data[i];
      req_exc[i]                                = s_exc[i];
    end
  endtask

  // Inputs change just after posedge; everything is observed at the following negedge.
  task automatic cycleStart();
    applyStimulus();
    @(negedge clk);
    fire       = req_valid & req_ready;
    flush_seen = flush;
  endtask

  task automatic cycleEnd();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (flush_seen) begin
        s_valid[i] = 1'b0;
      end else if (fire[i]) begin
        if (s_left[i] > 0) begin
          s_left[i]--;
          s_gen[i]++;
          s_idx[i]  = genIdx(i, s_gen[i]);
          s_data[i] = genData(i, s_gen[i]);
          s_exc[i]  = genExc(i, s_gen[i]);
        end else begin
          s_valid[i] = 1'b0;
        end
      end
    end
    flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && fill_valid && fill_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_fill: got src %0d idx %0d, want no transfer", fill_src, fill_rob_idx);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("fill_src", 32'(fill_src), 32'(mon_e.src));
        checkOutput("fill_rob_idx", 32'(fill_rob_idx), 32'(mon_e.idx));
        checkOutput("fill_data", fill_data, mon_e.data);
        checkOutput("fill_exc", 32'(fill_exc), 32'(mon_e.exc));
      end
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    fill_ready = 1'b0;
    fire       = '0;
    flush_seen = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_valid[i] = 1'b0;
      s_idx[i]   = '0;
      s_data[i]  = '0;
      s_exc[i]   = 1'b0;
      s_left[i]  = 0;
      s_gen[i]   = 0;
    end
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    cycleStart();
    checkOutput("reset_fill_valid", 32'(fill_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_fill_src", 32'(fill_src), 32'd0);
    checkOutput("reset_fill_idx", 32'(fill_rob_idx), 32'd0);
    checkOutput("reset_fill_data", fill_data, 32'd0);
    cycleEnd();

    // Four requesters with two results each, ROB always ready.
    fill_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      loadReq(i, genIdx(i, 0), genData(i, 0), genExc(i, 0), 1);
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NUM_REQ; i++)
        pushExp(SRC_W'(i), genIdx(i, n), genData(i, n), genExc(i, n));
    for (int c = 0; c < 8; c++) begin
      cycleStart();
      checkOutput("rr_onehot_ready", 32'($countones(req_ready)), 32'd1);
`ifndef ROB_FILL_ARB_PIPE_EN
      checkOutput("rr_fill_src", 32'(fill_src), 32'(c % NUM_REQ));
`endif
      cycleEnd();
    end
    repeat (2) begin
      cycleStart();
      cycleEnd();
    end

`ifndef ROB_FILL_ARB_PIPE_EN
    // Stall on req1 while req2 arrives; the grant must stay on req1.
    fill_ready = 1'b0;
    loadReq(1, 5'd7, 32'hDEAD_BEEF, 1'b0, 0);
    pushExp(2'd1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    pushExp(2'd2, 5'd9, 32'h2222_0000, 1'b1);
    for (int c = 0; c < 3; c++) begin
      if (c == 1)
        loadReq(2, 5'd9, 32'h2222_0000, 1'b1, 0);
      cycleStart();
      checkOutput("hold_valid", 32'(fill_valid), 32'd1);
      checkOutput("hold_src", 32'(fill_src), 32'd1);
      checkOutput("hold_idx", 32'(fill_rob_idx), 32'd7);
      checkOutput("hold_ready", 32'(req_ready), 32'd0);
      cycleEnd();
    end
    fill_ready = 1'b1;
    cycleStart();
    checkOutput("release_ready", 32'(req_ready), 32'b0010);
    cycleEnd();
    cycleStart();
    checkOutput("after_hold_src", 32'(fill_src), 32'd2);
    checkOutput("after_hold_ready", 32'(req_ready), 32'b0100);
    cycleEnd();
`else
    // One-deep output register: accept, stall while full, then drain and refill back to back.
    fill_ready = 1'b0;
    loadReq(0, 5'd3, 32'h0BAD_F00D, 1'b0, 0);
    pushExp(2'd0, 5'd3, 32'h0BAD_F00D, 1'b0);
    pushExp(2'd1, 5'd4, 32'h1234_5678, 1'b1);
    pushExp(2'd2, 5'd5, 32'h5555_AAAA, 1'b0);
    cycleStart();
    checkOutput("pipe_accept_ready", 32'(req_ready), 32'b0001);
    checkOutput("pipe_latency_valid", 32'(fill_valid), 32'd0);
    cycleEnd();
    loadReq(1, 5'd4, 32'h1234_5678, 1'b1, 0);
    repeat (2) begin
      cycleStart();
      checkOutput("pipe_out_valid", 32'(fill_valid), 32'd1);
      checkOutput("pipe_out_src", 32'(fill_src), 32'd0);
      checkOutput("pipe_out_idx", 32'(fill_rob_idx), 32'd3);
      checkOutput("pipe_stall_ready", 32'(req_ready), 32'd0);
      cycleEnd();
    end
    fill_ready = 1'b1;
    cycleStart();
    checkOutput("pipe_drain_ready", 32'(req_ready), 32'b0010);
    cycleEnd();
    loadReq(2, 5'd5, 32'h5555_AAAA, 1'b0, 0);
    cycleStart();
    checkOutput("pipe_second_src", 32'(fill_src), 32'd1);
    checkOutput("pipe_refill_ready", 32'(req_ready), 32'b0100);
    cycleEnd();
    cycleStart();
    checkOutput("pipe_third_src", 32'(fill_src), 32'd2);
    cycleEnd();
    cycleStart();
    checkOutput("pipe_empty_valid", 32'(fill_valid), 32'd0);
    cycleEnd();
`endif

    // Pointer sits at 3 here; req0/req1 must win in wrapped order.
    fill_ready = 1'b1;
    loadReq(0, 5'd10, 32'hA0A0_0000, 1'b0, 0);
    loadReq(1, 5'd11, 32'hA1A1_0001, 1'b1, 0);
    pushExp(2'd0, 5'd10, 32'hA0A0_0000, 1'b0);
    pushExp(2'd1, 5'd11, 32'hA1A1_0001, 1'b1);
    cycleStart();
`ifndef ROB_FILL_ARB_PIPE_EN
    checkOutput("wrap_first_src", 32'(fill_src), 32'd0);
`endif
    cycleEnd();
    cycleStart();
`ifndef ROB_FILL_ARB_PIPE_EN
    checkOutput("wrap_second_src", 32'(fill_src), 32'd1);
`endif
    cycleEnd();
    repeat (2) begin
      cycleStart();
      cycleEnd();
    end

`ifndef ROB_FILL_ARB_PIPE_EN
    // Flush while holding req2: nothing transfers and the pointer stays at 2.
    fill_ready = 1'b0;
    loadReq(2, 5'd12, 32'h5A5A_0002, 1'b0, 0);
    cycleStart();
    checkOutput("flush_hold_src", 32'(fill_src), 32'd2);
    cycleEnd();
    flush      = 1'b1;
    fill_ready = 1'b1;
    cycleStart();
    checkOutput("flush_fill_valid", 32'(fill_valid), 32'd0);
    checkOutput("flush_req_ready", 32'(req_ready), 32'd0);
    cycleEnd();
    loadReq(1, 5'd13, 32'hB1B1_0001, 1'b0, 0);
    loadReq(2, 5'd14, 32'hB2B2_0002, 1'b1, 0);
    pushExp(2'd2, 5'd14, 32'hB2B2_0002, 1'b1);
    pushExp(2'd1, 5'd13, 32'hB1B1_0001, 1'b0);
    cycleStart();
    checkOutput("post_flush_valid", 32'(fill_valid), 32'd1);
    checkOutput("post_flush_src", 32'(fill_src), 32'd2);
    cycleEnd();
    cycleStart();
    checkOutput("post_flush_next_src", 32'(fill_src), 32'd1);
    cycleEnd();
`endif

    fill_ready = 1'b1;
    repeat (3) begin
      cycleStart();
      cycleEnd();
    end
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
